logic_unit_pipe: RTL and testbench
==================================

// Module: logic_unit_pipe
// PURPOSE
//   Parametrised, pipelined bitwise logic unit; successor to the fixed 16-bit
//   combinational AND/OR/XOR blocks in the ALU datapath. One unit does all eight
//   bitwise ops, selected per transaction, with result flags.
//   Two register stages, valid/ready on both sides, one result per cycle when
//   there is no backpressure. Sits between decode/operand-read and writeback.
// PARAMETERS
//   WIDTH   16  operand/result width in bits (>=2)
// PORTS
//   clk         in   1      single clock, all state on rising edge
//   rst_n       in   1      async active-low reset
//   in_valid    in   1      operand beat valid
//   in_ready    out  1      unit can accept a beat this cycle
//   in_a        in   WIDTH  operand A
//   in_b        in   WIDTH  operand B
//   in_op       in   3      op select (encoding below)
//   out_valid   out  1      result beat valid
//   out_ready   in   1      consumer accepts result this cycle
//   out_res     out  WIDTH  result
//   out_zero    out  1      out_res == 0
//   out_parity  out  1      XOR-reduce of out_res
//   out_ones    out  1      out_res == all ones
// BEHAVIOUR
//   - Op encoding: 000 AND; 001 OR; 010 XOR; 011 ANDN (A&~B); 100 NAND;
//     101 NOR; 110 XNOR; 111 PASSA (res=A, B ignored).
//   - Reset (async assert, sync release): s1_valid=0, s2_valid=0, out_valid=0,
//     out_res=0, out_zero=0, out_parity=0, out_ones=0. in_ready=1 once rst_n=1.
//   - S1 registers {a,b,op} on input handshake (in_valid & in_ready).
//   - S2 registers the computed result and all three flags from S1.
//     Flags are computed in S2 input logic, never in output logic.
//   - adv2 = !s2_valid | out_ready; adv1 = !s1_valid | adv2.
//     in_ready = adv1 (combinational; no in_valid -> in_ready path).
//   - Latency: 2 cycles from accepted input to out_valid. Throughput 1/cycle.
//   - Backpressure: when out_ready=0 and out_valid=1, out_* are held stable.
//     S1 holds its beat if S2 is occupied. When both stages are full,
//     in_ready=0.
//   - Simultaneous events: an S2 drain, an S1->S2 move and a new input accept
//     can all happen in one cycle. No beat is lost, duplicated or reordered.
//   - Data registers load only on their own stage advance with valid data.
//     Bubbles do not change out_res.
//   - out_valid must not drop without a handshake.
//   - Reset mid-operation: in-flight beats are discarded and outputs return
//     to reset values immediately.
//   - Undefined in_op is impossible (3-bit, fully decoded).
//     in_a/in_b are don't-care when in_valid=0.
// STRUCTURE
//   - Shared include logic_ops.vh: `define LOP_AND..LOP_PASSA (3'b000..3'b111),
//     `define LOP_W 3. Shared with decode.
//   - Sub-module logic_core #(WIDTH): combinational {a,b,op} -> {res,zero,
//     parity,ones}. Instantiated once, between S1 and S2.
//   - Top holds only the two stage registers and the handshake logic.
// TESTING  (WIDTH=16 unless noted)
//   1. Reset: rst_n=0 mid-stream with 2 beats in flight -> out_valid=0,
//      out_res=0 that same cycle. After release, in_ready=1 and no stale beat
//      appears.
//   2. All ops, A=16'hF0F0, B=16'hFF00, out_ready=1 -> res F000, FFF0, 0FF0,
//      00F0, 0FFF, 000F, F00F, F0F0 on cycles 2..9. Flags: PASSA parity=0;
//      AND zero=0.
//   3. Flags: XOR A=B=16'h1234 -> zero=1, parity=0. OR A=FFFF -> ones=1.
//      XOR A=0001, B=0 -> parity=1.
//   4. Backpressure: stream 5 beats, out_ready=0 for cycles 3-6 -> in_ready=0
//      from cycle 4. out_res is held, then 5 results in order with no gaps
//      after release.
//   5. Random in_valid/out_ready at 50%, 10k beats vs scoreboard model -> no
//      loss, no duplication, no reordering. Repeat with WIDTH=8 and WIDTH=32.
//   6. Full-pipe simultaneous drain+accept every cycle for 100 cycles ->
//      in_ready stays 1 and out_valid stays 1.

Source files
------------

// File: rtl/logic_unit_pipe_pkg.sv
// Shared definitions for the pipelined bitwise logic unit: op-select encoding
// common to decode and the logic core.
package logic_unit_pipe_pkg;

    localparam int LOP_W = 3;

    typedef enum logic [LOP_W-1:0] {
        LOP_AND   = 3'b000,
        LOP_OR    = 3'b001,
        LOP_XOR   = 3'b010,
        LOP_ANDN  = 3'b011,
        LOP_NAND  = 3'b100,
        LOP_NOR   = 3'b101,
        LOP_XNOR  = 3'b110,
        LOP_PASSA = 3'b111
    } lop_e;

endpackage

// File: rtl/logic_unit_pipe_core.sv
// Combinational bitwise op plus result flags; sits between the two pipeline
// registers of logic_unit_pipe.
module logic_core
    import logic_unit_pipe_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  lop_e             op_i,
    output logic [WIDTH-1:0] res_o,
    output logic             zero_o,
    output logic             parity_o,
    output logic             ones_o
);

    always_comb begin
        res_o = a_i;
        unique case (op_i)
            LOP_AND:   res_o = a_i & b_i;
            LOP_OR:    res_o = a_i | b_i;
            LOP_XOR:   res_o = a_i ^ b_i;
            LOP_ANDN:  res_o = a_i & ~b_i;
            LOP_NAND:  res_o = ~(a_i & b_i);
            LOP_NOR:   res_o = ~(a_i | b_i);
            LOP_XNOR:  res_o = ~(a_i ^ b_i);
            LOP_PASSA: res_o = a_i;
            default:   res_o = a_i;
        endcase
    end

    assign zero_o   = ~|res_o;
    assign parity_o = ^res_o;
    assign ones_o   = &res_o;

endmodule

// File: rtl/logic_unit_pipe.sv
// Two-stage pipelined bitwise logic unit: S1 captures operands, S2 captures
// the result and flags computed by logic_core.
module logic_unit_pipe
    import logic_unit_pipe_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [LOP_W-1:0] in_op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_res,
    output logic             out_zero,
    output logic             out_parity,
    output logic             out_ones
);

    logic             s1_valid_q, s1_valid_d;
    logic [WIDTH-1:0] s1_a_q, s1_a_d;
    logic [WIDTH-1:0] s1_b_q, s1_b_d;
    lop_e             s1_op_q, s1_op_d;

    logic             s2_valid_q, s2_valid_d;
    logic [WIDTH-1:0] s2_res_q, s2_res_d;
    logic             s2_zero_q, s2_zero_d;
    logic             s2_parity_q, s2_parity_d;
    logic             s2_ones_q, s2_ones_d;

    logic [WIDTH-1:0] core_res;
    logic             core_zero, core_parity, core_ones;
    logic             adv1, adv2;

    // Handshake: a beat transfers on a rising edge where valid & ready are
    // both high; a producer holds valid and data stable until it transfers,
    // and ready never depends on the same side's valid.
    assign adv2     = !s2_valid_q || out_ready;
    assign adv1     = !s1_valid_q || adv2;
    assign in_ready = adv1;

    logic_core #(.WIDTH(WIDTH)) u_core (
        .a_i      (s1_a_q),
        .b_i      (s1_b_q),
        .op_i     (s1_op_q),
        .res_o    (core_res),
        .zero_o   (core_zero),
        .parity_o (core_parity),
        .ones_o   (core_ones)
    );

    always_comb begin
        s1_valid_d  = s1_valid_q;
        s1_a_d      = s1_a_q;
        s1_b_d      = s1_b_q;
        s1_op_d     = s1_op_q;
        s2_valid_d  = s2_valid_q;
        s2_res_d    = s2_res_q;
        s2_zero_d   = s2_zero_q;
        s2_parity_d = s2_parity_q;
        s2_ones_d   = s2_ones_q;
        if (adv1) begin
            s1_valid_d = in_valid;
            if (in_valid) begin
                s1_a_d  = in_a;
                s1_b_d  = in_b;
                s1_op_d = lop_e'(in_op);
            end
        end
        // Bubbles advance the valid bit only, so out_res keeps its last value.
        if (adv2) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                s2_res_d    = core_res;
                s2_zero_d   = core_zero;
                s2_parity_d = core_parity;
                s2_ones_d   = core_ones;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q  <= 1'b0;
            s1_a_q      <= '0;
            s1_b_q      <= '0;
            s1_op_q     <= LOP_AND;
            s2_valid_q  <= 1'b0;
            s2_res_q    <= '0;
            s2_zero_q   <= 1'b0;
            s2_parity_q <= 1'b0;
            s2_ones_q   <= 1'b0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_a_q      <= s1_a_d;
            s1_b_q      <= s1_b_d;
            s1_op_q     <= s1_op_d;
            s2_valid_q  <= s2_valid_d;
            s2_res_q    <= s2_res_d;
            s2_zero_q   <= s2_zero_d;
            s2_parity_q <= s2_parity_d;
            s2_ones_q   <= s2_ones_d;
        end
    end

    assign out_valid  = s2_valid_q;
    assign out_res    = s2_res_q;
    assign out_zero   = s2_zero_q;
    assign out_parity = s2_parity_q;
    assign out_ones   = s2_ones_q;

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Bench for logic_unit_pipe (WIDTH=16): directed op/flag table, latency,
// backpressure, mid-stream reset, random handshakes and full-rate streaming.
module tb_logic_unit_pipe;

    localparam int W = 16;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_a;
    logic [W-1:0] in_b;
    logic [2:0]   in_op;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_res;
    logic         out_zero;
    logic         out_parity;
    logic         out_ones;

    logic_unit_pipe #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_a       (in_a),
        .in_b       (in_b),
        .in_op      (in_op),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_res    (out_res),
        .out_zero   (out_zero),
        .out_parity (out_parity),
        .out_ones   (out_ones)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_total = 0;
    int n_pass  = 0;
    int n_hs    = 0;

    // expected {res, zero, parity, ones}
    logic [W+2:0] exp_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    function automatic logic [W+2:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic [2:0] op);
        logic [W-1:0] r;
        case (op)
            3'b000:  r = a & b;
            3'b001:  r = a | b;
            3'b010:  r = a ^ b;
            3'b011:  r = a & ~b;
            3'b100:  r = ~(a & b);
            3'b101:  r = ~(a | b);
            3'b110:  r = ~(a ^ b);
            default: r = a;
        endcase
        return {r, (r == '0), ^r, (r == '1)};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // driver: hold a beat until accepted, recording its expected result
    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [2:0] op, input logic [W+2:0] exp);
        bit ok;
        ok       = 1'b0;
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        in_op    = op;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(negedge clk);
            if (in_ready) begin
                exp_q.push_back(exp);
                ok = 1'b1;
            end
            tick();
        end
        if (!ok) chk("send_timeout", 32'd0, 32'd1);
    endtask

    // scoreboard / output monitor
    logic         prev_v, prev_rdy;
    logic [W+2:0] prev_out;
    logic [W+2:0] e;
    initial prev_v = 1'b0;

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_v = 1'b0;
        end else begin
            if (prev_v && !prev_rdy) begin
                chk("hold_valid", 32'(out_valid), 32'd1);
                chk("hold_out", 32'({out_res, out_zero, out_parity, out_ones}), 32'(prev_out));
            end
            if (out_valid && out_ready) begin
                n_hs++;
                if (exp_q.size() == 0) begin
                    chk("unexpected_out", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("result", 32'({out_res, out_zero, out_parity, out_ones}), 32'(e));
                end
            end
            prev_v   = out_valid;
            prev_rdy = out_ready;
            prev_out = {out_res, out_zero, out_parity, out_ones};
        end
    end

    typedef struct {
        logic [2:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] res;
        logic         zero;
        logic         parity;
        logic         ones;
    } vec_t;

    vec_t vecs[12];
    logic [W-1:0] held;
    int hs0;
    int acc;

    initial begin
        vecs[0]  = '{3'b000, 16'hF0F0, 16'hFF00, 16'hF000, 1'b0, 1'b0, 1'b0};
        vecs[1]  = '{3'b001, 16'hF0F0, 16'hFF00, 16'hFFF0, 1'b0, 1'b0, 1'b0};
        vecs[2]  = '{3'b010, 16'hF0F0, 16'hFF00, 16'h0FF0, 1'b0, 1'b0, 1'b0};
        vecs[3]  = '{3'b011, 16'hF0F0, 16'hFF00, 16'h00F0, 1'b0, 1'b0, 1'b0};
        vecs[4]  = '{3'b100, 16'hF0F0, 16'hFF00, 16'h0FFF, 1'b0, 1'b0, 1'b0};
        vecs[5]  = '{3'b101, 16'hF0F0, 16'hFF00, 16'h000F, 1'b0, 1'b0, 1'b0};
        vecs[6]  = '{3'b110, 16'hF0F0, 16'hFF00, 16'hF00F, 1'b0, 1'b0, 1'b0};
        vecs[7]  = '{3'b111, 16'hF0F0, 16'hFF00, 16'hF0F0, 1'b0, 1'b0, 1'b0};
        vecs[8]  = '{3'b010, 16'h1234, 16'h1234, 16'h0000, 1'b1, 1'b0, 1'b0};
        vecs[9]  = '{3'b001, 16'hFFFF, 16'h0000, 16'hFFFF, 1'b0, 1'b0, 1'b1};
        vecs[10] = '{3'b010, 16'h0001, 16'h0000, 16'h0001, 1'b0, 1'b1, 1'b0};
        vecs[11] = '{3'b111, 16'h8000, 16'hFFFF, 16'h8000, 1'b0, 1'b1, 1'b0};

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        in_op     = '0;
        out_ready = 1'b1;
        tick();
        tick();
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_res", 32'(out_res), 32'd0);
        chk("rst_flags", 32'({out_zero, out_parity, out_ones}), 32'd0);
        rst_n = 1'b1;
        tick();
        chk("rst_in_ready", 32'(in_ready), 32'd1);

        // latency: accepted at edge 0, visible after edge 2
        send(16'h00FF, 16'h0F0F, 3'b000, model(16'h00FF, 16'h0F0F, 3'b000));
        in_valid = 1'b0;
        chk("lat_s1_only", 32'(out_valid), 32'd0);
        tick();
        chk("lat_out_valid", 32'(out_valid), 32'd1);
        chk("lat_out_res", 32'(out_res), 32'h000F);
        tick();
        tick();

        // op/flag table, streamed back to back
        for (int i = 0; i < 12; i++)
            send(vecs[i].a, vecs[i].b, vecs[i].op,
                 {vecs[i].res, vecs[i].zero, vecs[i].parity, vecs[i].ones});
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        chk("table_drained", 32'(exp_q.size()), 32'd0);

        // backpressure: fill both stages, hold, then release with no gaps
        out_ready = 1'b0;
        send(16'h1111, 16'h0101, 3'b000, 32'({16'h0101, 1'b0, 1'b0, 1'b0}));
        send(16'h2222, 16'h0202, 3'b001, 32'({16'h2222, 1'b0, 1'b0, 1'b0}));
        in_a     = 16'h3333;
        in_b     = 16'h0000;
        in_op    = 3'b111;
        in_valid = 1'b1;
        chk("bp_in_ready_low", 32'(in_ready), 32'd0);
        chk("bp_out_valid", 32'(out_valid), 32'd1);
        held = out_res;
        chk("bp_first_res", 32'(held), 32'h0101);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("bp_stall_ready", 32'(in_ready), 32'd0);
            chk("bp_held_res", 32'(out_res), 32'(held));
        end
        out_ready = 1'b1;
        hs0 = n_hs;
        send(16'h3333, 16'h0000, 3'b111, 32'({16'h3333, 1'b0, 1'b0, 1'b0}));
        send(16'h4444, 16'h4444, 3'b110, 32'({16'hFFFF, 1'b0, 1'b0, 1'b1}));
        send(16'h5555, 16'hAAAA, 3'b101, 32'({16'h0000, 1'b1, 1'b0, 1'b0}));
        in_valid = 1'b0;
        tick();
        tick();
        chk("bp_no_gaps", 32'(n_hs - hs0), 32'd5);
        chk("bp_drained", 32'(exp_q.size()), 32'd0);

        // reset with two beats in flight
        out_ready = 1'b0;
        send(16'hAAAA, 16'h5555, 3'b001, model(16'hAAAA, 16'h5555, 3'b001));
        send(16'hBEEF, 16'h0000, 3'b111, model(16'hBEEF, 16'h0000, 3'b111));
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_out_res", 32'(out_res), 32'd0);
        chk("midrst_flags", 32'({out_zero, out_parity, out_ones}), 32'd0);
        exp_q.delete();
        @(negedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        out_ready = 1'b1;
        chk("midrst_in_ready", 32'(in_ready), 32'd1);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("midrst_no_stale", 32'(out_valid), 32'd0);
        end

        // full rate: drain and accept every cycle
        for (int i = 0; i < 100; i++) begin
            logic [W-1:0] ra, rb;
            logic [2:0]   rop;
            ra  = W'($urandom);
            rb  = W'($urandom);
            rop = 3'($urandom_range(0, 7));
            send(ra, rb, rop, model(ra, rb, rop));
            if (i >= 1) begin
                chk("full_in_ready", 32'(in_ready), 32'd1);
                chk("full_out_valid", 32'(out_valid), 32'd1);
            end
        end
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        chk("full_drained", 32'(exp_q.size()), 32'd0);

        // random valid/ready at 50%
        acc = 0;
        for (int cyc = 0; cyc < 40000 && acc < 3000; cyc++) begin
            in_valid  = 1'($urandom_range(0, 1));
            in_a      = W'($urandom);
            in_b      = W'($urandom);
            in_op     = 3'($urandom_range(0, 7));
            out_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            if (in_valid && in_ready) begin
                exp_q.push_back(model(in_a, in_b, in_op));
                acc++;
            end
            tick();
        end
        chk("rand_accepted", 32'(acc), 32'd3000);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 50 && exp_q.size() != 0; i++) tick();
        chk("rand_drained", 32'(exp_q.size()), 32'd0);
        tick();
        chk("final_idle", 32'(out_valid), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
